mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Bus responder for the core's two initiator buses: instruction fetch and data load/store.
- Serializes both onto one external memory bus, using the same access/ack protocol toward memory.
- Instantiated at top level between the core and the memory/SDRAM controller.
- Data bus has priority; an anti-starvation counter guarantees instruction fetches make progress.

Parameters:
- max_data_burst, 4: consecutive data grants allowed while an instruction request waits. Range 1-15.
- timeout_cycles, 255: cycles in BUSY without q_m_ack before abort. Used only with MEM_ARB_TIMEOUT_EN. Range 1-255.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-high.
- instr_m_addr  in  19  word address [19:1] from prefetch.
- instr_m_access  in  1  fetch request, held until ack.
- instr_m_ack  out  1  one-cycle completion pulse to prefetch.
- instr_m_data_out  out  16  fetched word, valid while instr_m_ack=1.
- data_m_addr  in  19  word address [19:1] from loadstore.
- data_m_wr_data  in  16  store data.
- data_m_access  in  1  data request, held until ack.
- data_m_wr_en  in  1  1=store, 0=load.
- data_m_bytesel  in  2  byte lanes [1]=high, [0]=low.
- data_m_ack  out  1  one-cycle completion pulse to loadstore.
- data_m_rd_data  out  16  load data, valid while data_m_ack=1.
- q_m_addr  out  19  memory word address.
- q_m_data_out  out  16  memory write data.
- q_m_data_in  in  16  memory read data.
- q_m_access  out  1  memory request.
- q_m_ack  in  1  memory completion pulse.
- q_m_wr_en  out  1  memory write enable.
- q_m_bytesel  out  2  memory byte lanes.
- bus_error  out  1  one-cycle pulse on timeout abort.

Behaviour:
- State machine: IDLE and BUSY. Grant register: NONE, INSTR or DATA. Burst counter: 4 bits.
- Reset:
  - state=IDLE, grant=NONE, burst count=0.
  - All q_m_* outputs, instr_m_ack, data_m_ack and bus_error are 0.
  - Asserting reset mid-transaction drops q_m_access immediately (asynchronous); no ack is ever produced for the aborted request.
- IDLE arbitration (evaluated at each clock edge):
  - Grant DATA if data_m_access=1, unless instr_m_access=1 and burst count = max_data_burst; in that case grant INSTR.
  - Otherwise grant INSTR if instr_m_access=1.
  - With a grant: latch addr, wr_data, wr_en and bytesel into the q_m_* registers, set q_m_access=1, go to BUSY.
  - An INSTR grant forces q_m_wr_en=0, q_m_bytesel=2'b11 and q_m_data_out unchanged.
- Burst counter:
  - On a DATA grant with instr_m_access=1: increments, saturating at max_data_burst.
  - Cleared on an INSTR grant, or on any IDLE cycle with instr_m_access=0.
- BUSY:
  - q_m_* outputs hold stable.
  - On q_m_ack=1, the granted port's ack is driven combinationally in the same cycle.
  - The matching read-data output is a combinational passthrough of q_m_data_in.
  - The ungranted ack stays 0.
  - At the next edge: q_m_access=0, grant=NONE, state=IDLE.
- Latency: request sampled at edge N gives q_m_access high from cycle N+1. Zero-wait memory acks in cycle N+1. Minimum 2 cycles per transfer.
- Turnaround: one mandatory IDLE cycle between transactions. A master that holds access in the IDLE cycle is treated as a new request.
- Outside their ack cycle, instr_m_data_out and data_m_rd_data are 0.
- The address is passed unchanged (19 bits). No width conversion.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Enabled: an 8-bit counter clears on entering BUSY and increments each BUSY cycle without q_m_ack.
  - When the count reaches timeout_cycles with q_m_ack=0, the granted port's ack pulses for one cycle with read data 16'hffff.
  - bus_error pulses in that same cycle.
  - q_m_access drops at the next edge; state returns to IDLE.
  - If q_m_ack=1 in the timeout cycle, the normal ack wins and bus_error stays 0.
- Disabled: BUSY waits indefinitely; bus_error is tied 0; the port remains present.

Test Plan:
- Single load: data_m_access=1, addr 19'h00100, memory acks 2 cycles after q_m_access with 16'hbeef -> q_m_addr=19'h00100, q_m_wr_en=0, data_m_ack one cycle with data_m_rd_data=16'hbeef, instr_m_ack=0.
- Store with bytesel=2'b10, wr_data=16'h12ab -> q_m_wr_en=1, q_m_bytesel=2'b10, q_m_data_out=16'h12ab held stable until q_m_ack.
- Instr and data both requesting continuously, zero-wait memory, max_data_burst=4 -> grant order D,D,D,D,I,D,D,D,D,I.
- Simultaneous requests from IDLE with burst count 0 -> DATA granted first; INSTR served in the following transaction after one IDLE cycle.
- Reset asserted in BUSY before q_m_ack -> q_m_access=0 immediately, no master ack; a later request is served normally.
- MEM_ARB_TIMEOUT_EN with timeout_cycles=8, memory never acks -> instr_m_ack and bus_error pulse 8 cycles after q_m_access rises, instr_m_data_out=16'hffff; without the macro, the bench sees no ack after 300 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - data-priority arbiter of instruction and data buses onto one memory bus
// Optional memory timeout abort: define MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
   parameter int max_data_burst = 4,
   parameter int timeout_cycles = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [18:0] instr_m_addr,
   input  logic        instr_m_access,
   output logic        instr_m_ack,
   output logic [15:0] instr_m_data_out,
   input  logic [18:0] data_m_addr,
   input  logic [15:0] data_m_wr_data,
   input  logic        data_m_access,
   input  logic        data_m_wr_en,
   input  logic [1:0]  data_m_bytesel,
   output logic        data_m_ack,
   output logic [15:0] data_m_rd_data,
   output logic [18:0] q_m_addr,
   output logic [15:0] q_m_data_out,
   input  logic [15:0] q_m_data_in,
   output logic        q_m_access,
   input  logic        q_m_ack,
   output logic        q_m_wr_en,
   output logic [1:0]  q_m_bytesel,
   output logic        bus_error
);

   typedef enum logic {IDLE, BUSY} state_t;
   typedef enum logic [1:0] {GRANT_NONE, GRANT_INSTR, GRANT_DATA} grant_t;

   localparam logic [3:0] BURST_MAX = 4'(max_data_burst);

   if (max_data_burst < 1 || max_data_burst > 15) begin : g_bad_burst
      $error("mem_arbiter: max_data_burst must be 1..15");
   end
   if (timeout_cycles < 1 || timeout_cycles > 255) begin : g_bad_timeout
      $error("mem_arbiter: timeout_cycles must be 1..255");
   end

   state_t      state, state_next;
   grant_t      grant, grant_next;
   logic [3:0]  burst_cnt, burst_next;
   logic        done;
   logic        timeout_hit;
   logic [15:0] rd_value;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_VAL = 8'(timeout_cycles);
   logic [7:0] wait_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if (state == IDLE) begin
         wait_cnt <= '0;
      end else if (!q_m_ack) begin
         wait_cnt <= wait_cnt + 8'd1;
      end
   end

   assign timeout_hit = (state == BUSY) && !q_m_ack && (wait_cnt == TIMEOUT_VAL);
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         grant     <= GRANT_NONE;
         burst_cnt <= '0;
      end else begin
         state     <= state_next;
         grant     <= grant_next;
         burst_cnt <= burst_next;
      end
   end

   always_comb begin
      state_next       = state;
      grant_next       = grant;
      burst_next       = burst_cnt;
      done             = (state == BUSY) && (q_m_ack || timeout_hit);
      // A timed-out transfer returns all ones to the waiting master
      rd_value         = q_m_ack ? q_m_data_in : 16'hffff;
      instr_m_ack      = done && (grant == GRANT_INSTR);
      data_m_ack       = done && (grant == GRANT_DATA);
      instr_m_data_out = instr_m_ack ? rd_value : 16'h0000;
      data_m_rd_data   = data_m_ack ? rd_value : 16'h0000;
      bus_error        = timeout_hit;
      case (state)
         IDLE: begin
            if (data_m_access && !(instr_m_access && burst_cnt == BURST_MAX)) begin
               grant_next = GRANT_DATA;
               state_next = BUSY;
               if (!instr_m_access) begin
                  burst_next = '0;
               end else if (burst_cnt != BURST_MAX) begin
                  burst_next = burst_cnt + 4'd1;
               end
            end else if (instr_m_access) begin
               grant_next = GRANT_INSTR;
               state_next = BUSY;
               burst_next = '0;
            end else begin
               burst_next = '0;
            end
         end
         BUSY: begin
            if (done) begin
               state_next = IDLE;
               grant_next = GRANT_NONE;
            end
         end
         default: begin
            state_next = IDLE;
            grant_next = GRANT_NONE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_m_addr     <= '0;
         q_m_data_out <= '0;
         q_m_access   <= 1'b0;
         q_m_wr_en    <= 1'b0;
         q_m_bytesel  <= '0;
      end else if (state == IDLE && state_next == BUSY) begin
         q_m_access <= 1'b1;
         if (grant_next == GRANT_DATA) begin
            q_m_addr     <= data_m_addr;
            q_m_data_out <= data_m_wr_data;
            q_m_wr_en    <= data_m_wr_en;
            q_m_bytesel  <= data_m_bytesel;
         end else begin
            // Fetches leave the write-data register untouched
            q_m_addr    <= instr_m_addr;
            q_m_wr_en   <= 1'b0;
            q_m_bytesel <= 2'b11;
         end
      end else if (done) begin
         q_m_access <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
// Completions are expected in grant order; memory returns addr[15:0] + 16'hbdef.
module tb_mem_arbiter;

   typedef struct {
      logic [18:0] addr;
      logic [15:0] wdata;
      logic        wr;
      logic [1:0]  bsel;
   } req_t;

   typedef struct {
      logic        is_data;
      logic [18:0] addr;
      logic [15:0] wdata;
      logic        wr;
      logic [1:0]  bsel;
      logic [15:0] rdata;
      logic        berr;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [18:0] instr_m_addr = '0;
   logic        instr_m_access = 1'b0;
   logic        instr_m_ack;
   logic [15:0] instr_m_data_out;
   logic [18:0] data_m_addr = '0;
   logic [15:0] data_m_wr_data = '0;
   logic        data_m_access = 1'b0;
   logic        data_m_wr_en = 1'b0;
   logic [1:0]  data_m_bytesel = '0;
   logic        data_m_ack;
   logic [15:0] data_m_rd_data;
   logic [18:0] q_m_addr;
   logic [15:0] q_m_data_out;
   logic [15:0] q_m_data_in = '0;
   logic        q_m_access;
   logic        q_m_ack = 1'b0;
   logic        q_m_wr_en;
   logic [1:0]  q_m_bytesel;
   logic        bus_error;

   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   rise_cyc = 0;
   int   ack_count = 0;
   int   mem_wait = 0;
   int   wait_cnt = 0;
   logic mem_enable = 1'b1;
   logic prev_access = 1'b0;
   logic prev_ack = 1'b0;
   logic [37:0] snap = '0;
   logic [15:0] exp_last_wdata = '0;

   req_t dq[$];
   req_t iq[$];
   exp_t exp_q[$];

   mem_arbiter #(.max_data_burst(4), .timeout_cycles(8)) dut (
      .clk(clk), .reset(reset),
      .instr_m_addr(instr_m_addr), .instr_m_access(instr_m_access),
      .instr_m_ack(instr_m_ack), .instr_m_data_out(instr_m_data_out),
      .data_m_addr(data_m_addr), .data_m_wr_data(data_m_wr_data),
      .data_m_access(data_m_access), .data_m_wr_en(data_m_wr_en),
      .data_m_bytesel(data_m_bytesel), .data_m_ack(data_m_ack),
      .data_m_rd_data(data_m_rd_data),
      .q_m_addr(q_m_addr), .q_m_data_out(q_m_data_out), .q_m_data_in(q_m_data_in),
      .q_m_access(q_m_access), .q_m_ack(q_m_ack), .q_m_wr_en(q_m_wr_en),
      .q_m_bytesel(q_m_bytesel), .bus_error(bus_error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [15:0] mem_word(input logic [18:0] a);
      return a[15:0] + 16'hbdef;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_masters();
      if (dq.size() != 0) begin
         data_m_access  = 1'b1;
         data_m_addr    = dq[0].addr;
         data_m_wr_data = dq[0].wdata;
         data_m_wr_en   = dq[0].wr;
         data_m_bytesel = dq[0].bsel;
      end else begin
         data_m_access  = 1'b0;
         data_m_addr    = '0;
         data_m_wr_data = '0;
         data_m_wr_en   = 1'b0;
         data_m_bytesel = '0;
      end
      if (iq.size() != 0) begin
         instr_m_access = 1'b1;
         instr_m_addr   = iq[0].addr;
      end else begin
         instr_m_access = 1'b0;
         instr_m_addr   = '0;
      end
   endtask

   task automatic push_data(input logic [18:0] a, input logic wr, input logic [15:0] wd,
                            input logic [1:0] bs);
      req_t r;
      r.addr = a; r.wdata = wd; r.wr = wr; r.bsel = bs;
      dq.push_back(r);
      drive_masters();
   endtask

   task automatic push_instr(input logic [18:0] a);
      req_t r;
      r.addr = a; r.wdata = '0; r.wr = 1'b0; r.bsel = 2'b11;
      iq.push_back(r);
      drive_masters();
   endtask

   task automatic expect_data(input logic [18:0] a, input logic wr, input logic [15:0] wd,
                              input logic [1:0] bs, input int lat);
      exp_t e;
      e.is_data = 1'b1; e.addr = a; e.wdata = wd; e.wr = wr; e.bsel = bs;
      e.rdata = mem_word(a); e.berr = 1'b0; e.lat = lat;
      exp_last_wdata = wd;
      exp_q.push_back(e);
   endtask

   task automatic expect_instr(input logic [18:0] a, input int lat, input logic timed_out);
      exp_t e;
      e.is_data = 1'b0; e.addr = a; e.wdata = exp_last_wdata; e.wr = 1'b0; e.bsel = 2'b11;
      e.rdata = timed_out ? 16'hffff : mem_word(a); e.berr = timed_out; e.lat = lat;
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #3;
   endtask

   task automatic drain(input string tag, input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || dq.size() != 0 || iq.size() != 0) && n < budget) begin
         step();
         n++;
      end
      check(tag, exp_q.size() + dq.size() + iq.size(), 0);
      step();
   endtask

   // Memory model: acks mem_wait cycles after q_m_access rises
   always @(negedge clk) begin
      if (mem_enable && q_m_access && !q_m_ack) begin
         if (wait_cnt == mem_wait) begin
            q_m_ack     = 1'b1;
            q_m_data_in = mem_word(q_m_addr);
            wait_cnt    = 0;
         end else begin
            wait_cnt++;
         end
      end else begin
         q_m_ack     = 1'b0;
         q_m_data_in = 16'hdead;
         wait_cnt    = 0;
      end
   end

   always begin
      exp_t e;
      @(negedge clk);
      #2;
      if (reset) begin
         prev_access = 1'b0;
         prev_ack    = 1'b0;
      end else begin
         if (q_m_access && !prev_access) begin
            rise_cyc = cyc;
            snap = {q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel};
         end else if (q_m_access) begin
            check("busy_hold", {q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel}, snap);
         end
         if (prev_ack) check("turnaround_idle", q_m_access, 1'b0);
         if (instr_m_ack || data_m_ack) begin
            ack_count++;
            check("ack_expected", exp_q.size() == 0, 1'b0);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("ack_port", {instr_m_ack, data_m_ack}, e.is_data ? 2'b01 : 2'b10);
               check("ack_rdata", e.is_data ? data_m_rd_data : instr_m_data_out, e.rdata);
               check("other_rdata", e.is_data ? instr_m_data_out : data_m_rd_data, 16'h0);
               check("q_addr", q_m_addr, e.addr);
               check("q_wr_en", q_m_wr_en, e.wr);
               check("q_bytesel", q_m_bytesel, e.bsel);
               check("q_data_out", q_m_data_out, e.wdata);
               check("bus_error", bus_error, e.berr);
               if (e.lat >= 0) check("ack_latency", cyc - rise_cyc, e.lat);
            end
            if (data_m_ack && dq.size() != 0) void'(dq.pop_front());
            if (instr_m_ack && iq.size() != 0) void'(iq.pop_front());
            drive_masters();
         end else begin
            check("idle_rdata", {instr_m_data_out, data_m_rd_data}, 32'h0);
            check("idle_bus_error", bus_error, 1'b0);
         end
         prev_ack    = instr_m_ack || data_m_ack;
         prev_access = q_m_access;
      end
   end

   initial begin
      int acks_before;
      int di;
      int ii;

      repeat (3) @(posedge clk);
      #3;
      check("rst_q_access", q_m_access, 1'b0);
      check("rst_q_regs", {q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel}, 38'h0);
      check("rst_acks", {instr_m_ack, data_m_ack, bus_error}, 3'b000);
      reset = 1'b0;
      step();

      // Single load, memory acks two cycles after the request reaches it
      mem_wait = 2;
      push_data(19'h00100, 1'b0, 16'h0000, 2'b11);
      expect_data(19'h00100, 1'b0, 16'h0000, 2'b11, 2);
      drain("load_drained", 20);

      // Store: request sampled at the next edge, q_m_access high right after it
      mem_wait = 3;
      push_data(19'h00200, 1'b1, 16'h12ab, 2'b10);
      expect_data(19'h00200, 1'b1, 16'h12ab, 2'b10, 3);
      @(posedge clk);
      #1;
      check("access_latency", q_m_access, 1'b1);
      check("store_wr_en", q_m_wr_en, 1'b1);
      check("store_bytesel", q_m_bytesel, 2'b10);
      check("store_data", q_m_data_out, 16'h12ab);
      drain("store_drained", 20);

      // Simultaneous requests from idle: data first, then instruction
      mem_wait = 1;
      push_data(19'h00300, 1'b0, 16'h5151, 2'b01);
      push_instr(19'h01400);
      expect_data(19'h00300, 1'b0, 16'h5151, 2'b01, 1);
      expect_instr(19'h01400, 1, 1'b0);
      drain("simul_drained", 30);

      // Continuous contention, zero-wait memory: D,D,D,D,I,D,D,D,D,I
      mem_wait = 0;
      for (int i = 0; i < 8; i++)
         push_data(19'h01000 + 19'(i), 1'(i % 2), 16'h3000 + 16'(i), 2'b01);
      push_instr(19'h40000);
      push_instr(19'h40001);
      di = 0;
      ii = 0;
      for (int k = 0; k < 10; k++) begin
         if (k == 4 || k == 9) begin
            expect_instr(19'h40000 + 19'(ii), 0, 1'b0);
            ii++;
         end else begin
            expect_data(19'h01000 + 19'(di), 1'(di % 2), 16'h3000 + 16'(di), 2'b01, 0);
            di++;
         end
      end
      drain("burst_drained", 60);

      // Reset while BUSY: access drops at once and no ack follows
      mem_wait = 6;
      push_data(19'h00500, 1'b0, 16'h7777, 2'b11);
      @(posedge clk);
      #1;
      check("abort_access_up", q_m_access, 1'b1);
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("abort_access_drop", q_m_access, 1'b0);
      check("abort_no_data_ack", data_m_ack, 1'b0);
      acks_before = ack_count;
      dq.delete();
      drive_masters();
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b0;
      exp_last_wdata = 16'h0000;
      repeat (10) step();
      check("abort_ack_count", ack_count, acks_before);
      mem_wait = 1;
      push_data(19'h00600, 1'b0, 16'h0000, 2'b11);
      expect_data(19'h00600, 1'b0, 16'h0000, 2'b11, 1);
      drain("post_reset_drained", 20);

      // Memory never acknowledges
      mem_enable = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      push_instr(19'h00700);
      expect_instr(19'h00700, 8, 1'b1);
      drain("timeout_drained", 40);
`else
      acks_before = ack_count;
      push_instr(19'h00700);
      repeat (300) step();
      check("no_timeout_ack", ack_count, acks_before);
      check("no_timeout_access", q_m_access, 1'b1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
